store_checker: RTL



---
 rtl/store_checker_pkg.sv | 23 ++
 rtl/store_checker_if.sv | 28 ++
 rtl/store_checker_cycle_timer.sv | 33 +++
 rtl/store_checker.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/store_checker_pkg.sv
// Shared types for the store checker: FSM states, failure codes and the
// table-index width helper used by the interface and the top.
package checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_MISMATCH = 2'b01,
      FC_TIMEOUT  = 2'b10,
      FC_RSVD     = 2'b11
   } fail_code_e;

   function automatic int idx_w(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/store_checker_if.sv
// Observed CPU store bus plus the expected-store table configuration port.
interface store_checker_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) ();
   localparam int IW = checker_pkg::idx_w(DEPTH);

   logic             memwrite;
   logic [WIDTH-1:0] aluout;
   logic [WIDTH-1:0] rd2;
   logic             cfg_we;
   logic [IW-1:0]    cfg_idx;
   logic [WIDTH-1:0] cfg_addr;
   logic [WIDTH-1:0] cfg_data;
   logic [WIDTH-1:0] cfg_mask;
   logic [IW:0]      cfg_count;
   logic             start;

   modport master (
      output memwrite, aluout, rd2, cfg_we, cfg_idx, cfg_addr, cfg_data,
             cfg_mask, cfg_count, start
   );

   modport slave (
      input memwrite, aluout, rd2, cfg_we, cfg_idx, cfg_addr, cfg_data,
            cfg_mask, cfg_count, start
   );
endinterface

// File: rtl/store_checker_cycle_timer.sv
// Run-length counter with terminal-count detect at TIMEOUT-1.
module cycle_timer #(
   parameter int  TIMEOUT = 1024,
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          expired
);
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (en)
         count_d = count_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count   = count_q;
   assign expired = (count_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/store_checker.sv
// Checks a CPU store stream against an ordered table of expected
// address/data/mask entries; reports pass, mismatch or timeout.
module store_checker
   import checker_pkg::*;
#(
   parameter int  WIDTH   = 32,
   parameter int  DEPTH   = 4,
   parameter int  TIMEOUT = 1024,
   localparam int IW      = idx_w(DEPTH),
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic                clk,
   input  logic                reset,
   store_checker_if.slave      bus,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [1:0]          fail_code,
   output logic [IW-1:0]       fail_idx,
   output logic [IW:0]         store_cnt,
   output logic [CW-1:0]       cycles
);
   state_e           state_q, state_d;
   logic [IW:0]      count_q, count_d;
   logic [IW:0]      store_cnt_q, store_cnt_d;
   logic [IW:0]      cnt_inc;
   logic [1:0]       fail_code_q, fail_code_d;
   logic [IW-1:0]    fail_idx_q, fail_idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [WIDTH-1:0] addr_q [DEPTH];
   logic [WIDTH-1:0] addr_d [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [WIDTH-1:0] mask_q [DEPTH];
   logic [WIDTH-1:0] mask_d [DEPTH];
   logic [WIDTH-1:0] sel_addr, sel_data, sel_mask;
   logic             hit;
   logic             timer_clear, timer_en, timer_expired;
   logic [CW-1:0]    timer_count;

   function automatic logic [IW:0] eff_count(input logic [IW:0] c);
      if (c == '0 || c > (IW+1)'(DEPTH))
         return (IW+1)'(DEPTH);
      return c;
   endfunction

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      mask_d = mask_q;
      if (state_q == ST_IDLE && bus.cfg_we) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.cfg_idx == IW'(i)) begin
               addr_d[i] = bus.cfg_addr;
               data_d[i] = bus.cfg_data;
               mask_d[i] = bus.cfg_mask;
            end
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (store_cnt_q == (IW+1)'(i)) begin
            sel_addr = addr_q[i];
            sel_data = data_q[i];
            sel_mask = mask_q[i];
         end
      end
   end

   assign hit     = (bus.aluout == sel_addr) && (((bus.rd2 ^ sel_data) & sel_mask) == '0);
   assign cnt_inc = store_cnt_q + (IW+1)'(1);

   // A store on the timeout cycle is judged before the timeout itself
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      store_cnt_d = store_cnt_q;
      fail_code_d = fail_code_q;
      fail_idx_d  = fail_idx_q;
      timer_clear = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.memwrite && !hit) begin
               state_d     = ST_FAIL;
               fail_code_d = FC_MISMATCH;
               fail_idx_d  = store_cnt_q[IW-1:0];
            end else begin
               if (bus.memwrite)
                  store_cnt_d = cnt_inc;
               if (bus.memwrite && cnt_inc == count_q) begin
                  state_d = ST_PASS;
               end else if (timer_expired) begin
                  state_d     = ST_FAIL;
                  fail_code_d = FC_TIMEOUT;
                  fail_idx_d  = store_cnt_d[IW-1:0];
               end
            end
         end
         default: begin
            if (bus.start) begin
               state_d     = ST_RUN;
               count_d     = eff_count(bus.cfg_count);
               store_cnt_d = '0;
               fail_code_d = FC_NONE;
               fail_idx_d  = '0;
               timer_clear = 1'b1;
            end
         end
      endcase
   end

   // The deciding edge does not count as a further RUN cycle
   assign timer_en = (state_q == ST_RUN) && (state_d == ST_RUN);

   assign busy_d = (state_d == ST_RUN);
   assign done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
   assign pass_d = (state_d == ST_PASS);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         store_cnt_q <= '0;
         fail_code_q <= '0;
         fail_idx_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            mask_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         store_cnt_q <= store_cnt_d;
         fail_code_q <= fail_code_d;
         fail_idx_q  <= fail_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         mask_q      <= mask_d;
      end
   end

   cycle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .en      (timer_en),
      .count   (timer_count),
      .expired (timer_expired)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_code = fail_code_q;
   assign fail_idx  = fail_idx_q;
   assign store_cnt = store_cnt_q;
   assign cycles    = timer_count;
endmodule
